wb_slave_mem: RTL

Wishbone classic-cycle responder (slave) with an internal 32-bit word memory. It is the target end for Wishbone_master transactions and gives that master a real, parameterisable peer in block and system benches. It generates ack/err handshakes with configurable wait states, supports byte-select writes, and registers read data.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_slave_mem_if.sv | 25 ++
 rtl/wb_mem_array.sv | 40 ++++
 rtl/wb_slave_mem.sv | 129 ++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone widths, slave FSM states and the latched request payload.
package wb_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_slv_state_e;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
    } wb_req_t;

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic bus bundle; signal names follow the slave's point of view.
interface wb_slave_mem_if;
    import wb_pkg::*;

    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic             wb_we_i;
    logic [WB_AW-1:0] wb_adr_i;
    logic [WB_DW-1:0] wb_dat_i;
    logic [WB_SW-1:0] wb_sel_i;
    logic [WB_DW-1:0] wb_dat_o;
    logic             wb_ack_o;
    logic             wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/wb_mem_array.sv
// DEPTH x 32 word storage: byte-lane synchronous write, combinational read, reset clears all words.
module wb_mem_array
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WB_DW-1:0]         wdata,
    input  logic [WB_SW-1:0]         sel,
    output logic [WB_DW-1:0]         rdata
);

    logic [WB_DW-1:0] mem_q [DEPTH];
    logic [WB_DW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int unsigned b = 0; b < WB_SW; b++) begin
                if (sel[b]) begin
                    mem_d[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic responder over a word memory with programmable wait states and
// out-of-range error termination.
module wb_slave_mem
    import wb_pkg::*;
#(
    parameter int unsigned      DEPTH       = 16,
    parameter int unsigned      WAIT_STATES = 1,
    parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    wb_slave_mem_if.slave wb
);

    localparam int unsigned      IW      = $clog2(DEPTH);
    localparam logic [WB_AW-1:0] SPAN    = WB_AW'(DEPTH * 4);
    localparam logic [3:0]       WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    wb_slv_state_e    state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    wb_req_t          req_q, req_d;
    logic             in_range_q, in_range_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [WB_DW-1:0] dat_q, dat_d;

    wb_req_t          live_req, cur_req;
    logic [WB_AW-1:0] cur_off;
    logic             range_hit, cur_in;
    logic [IW-1:0]    cur_idx;
    logic             enter_resp;
    logic             mem_we;
    logic [WB_DW-1:0] mem_rdata;

    // In IDLE a zero-wait request terminates straight from the live bus; otherwise use the latch.
    always_comb begin
        live_req  = '{we: wb.wb_we_i, adr: wb.wb_adr_i, dat: wb.wb_dat_i, sel: wb.wb_sel_i};
        cur_req   = (state_q == IDLE) ? live_req : req_q;
        cur_off   = cur_req.adr - BASE_ADDR;
        range_hit = (cur_req.adr >= BASE_ADDR) && (cur_off < SPAN);
        cur_in    = (state_q == IDLE) ? range_hit : in_range_q;
        cur_idx   = IW'(cur_off >> 2);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        in_range_d = in_range_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_d      = dat_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    req_d      = live_req;
                    in_range_d = range_hit;
                    if (WAIT_STATES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = WS_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!(wb.wb_cyc_i && wb.wb_stb_i)) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            state_d = RESP;
            ack_d   = cur_in;
            err_d   = !cur_in;
            if (!cur_req.we) begin
                dat_d = cur_in ? mem_rdata : '0;
            end
        end
    end

    assign mem_we = enter_resp && cur_in && cur_req.we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            in_range_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            in_range_q <= in_range_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
        end
    end

    wb_mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .idx   (cur_idx),
        .wdata (cur_req.dat),
        .sel   (cur_req.sel),
        .rdata (mem_rdata)
    );

    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;

endmodule
